stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control sequencer for the stopwatch counter datapath. It debounces two raw push-buttons and runs a four-state start/pause/lap/clear machine. It drives the stopwatch's count enable and a synchronous-looking clear pulse, and gives the display path a lap-capture strobe and a display-hold flag. It sits between the board buttons and the stopwatch counter, in the clock_1kHz domain.

## Interface
- DEBOUNCE_MS, 20: consecutive clock_1kHz cycles a synchronized button level must hold before it is accepted.
- HOLD_MS, 3000: cycles the lap snapshot stays frozen on the display before reverting to the live view.
- LAP_MAX, 9: saturation value of lap_count.
- clock_1kHz  in  1  system clock, 1 kHz.
- resetn  in  1  reset, asynchronous, active-low.
- btn_start_stop  in  1  raw button, active-high, asynchronous, bouncy.
- btn_lap_reset  in  1  raw button, active-high, asynchronous, bouncy.
- mode_active  in  1  stopwatch mode selected; button events are discarded while 0.
- enable_swt  out  1  count enable to the stopwatch counter.
- swt_resetn  out  1  active-low clear to the stopwatch counter; one-cycle low pulse.
- lap_capture  out  1  one-cycle pulse; the display path latches the counter digits on this edge.
- display_hold  out  1  display shows the latched lap snapshot instead of the live digits.
- lap_count  out  4  number of laps taken since the last clear; saturates at LAP_MAX.
- state  out  2  current state: IDLE=00, RUN=01, PAUSE=10, LAP=11.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer: a counter increments while the synchronized level differs from the accepted level and resets to 0 when they match.
  - When the counter reaches DEBOUNCE_MS, the accepted level flips.
- Event: one-cycle pulse on each rising edge of the accepted level. Releases and holds generate no events.
- Events are ignored (dropped, not queued) when mode_active=0. Debouncers keep running, and the state machine keeps its state, so the counter runs in the background.
- If both events occur in the same cycle, start_stop wins and the lap_reset event is dropped.
- State transitions:
  - IDLE: start -> RUN. lap -> no effect.
  - RUN: start -> PAUSE. lap -> LAP, with lap_capture pulse, lap_count+1 (saturating), and hold timer cleared.
  - LAP: start -> PAUSE, display_hold drops. lap -> stay in LAP, with a new lap_capture pulse, lap_count+1, and hold timer cleared. Hold timer reaching HOLD_MS-1 -> RUN.
  - PAUSE: start -> RUN. lap -> IDLE, with a swt_resetn low pulse and lap_count cleared to 0.
- Registered outputs, all decoded from the next state:
  - enable_swt = 1 in RUN and LAP.
  - display_hold = 1 in LAP only.
- Hold timer: 12 bits minimum, counts only in LAP, and is cleared on every capture.
- Reset values: state IDLE, enable_swt 0, swt_resetn 1, lap_capture 0, display_hold 0, lap_count 0, accepted levels 0, debounce and hold counters 0, synchronizers 0.
- Reset asserted mid-operation returns everything to the reset values immediately. A button held through reset release produces one event once debounced.

## Timing
- Debounce latency:
  - Raw input goes high and stays stable; edge 0 is the first edge that samples it.
  - Synchronized level appears after edge 1.
  - Accepted level flips at edge 1+DEBOUNCE_MS.
  - Event pulse is high during the following cycle.
  - State and all outputs update at edge 2+DEBOUNCE_MS.
- Any bounce shorter than DEBOUNCE_MS cycles produces no event.
- lap_capture and the swt_resetn low pulse last exactly one cycle and are aligned with the state change.
- enable_swt changes on the same edge as state.
- LAP auto-exit: the transition to RUN happens exactly HOLD_MS cycles after the edge that entered LAP or last captured, provided no event intervenes.
- Back-to-back accepted events are at least DEBOUNCE_MS cycles apart by construction. No other throttling is applied.

## Test plan
- Reset, then a clean start press held 50 cycles -> enable_swt=1 and state=01 exactly 22 edges after the first sampling edge; the release produces no further change.
- Start press with 5-cycle bounce bursts (each shorter than 20 cycles), then stable -> exactly one event; RUN reached 22 edges after the final stable transition.
- In RUN, lap press -> one-cycle lap_capture, display_hold=1, lap_count=1, enable_swt stays 1. With no further presses, state=RUN and display_hold=0 exactly 3000 cycles later.
- Ten lap presses in RUN/LAP -> lap_count saturates at 9. Then start press (PAUSE, enable_swt=0), then lap press -> one-cycle swt_resetn=0, lap_count=0, state=IDLE.
- Start and lap accepted in the same cycle while in RUN -> PAUSE, no lap_capture, lap_count unchanged. Presses with mode_active=0 -> no state or output change.
- resetn pulsed low in LAP mid-hold -> all outputs return to their reset values asynchronously; the next start press goes IDLE -> RUN normally.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounces the start/stop and lap/reset buttons and
// runs the IDLE/RUN/PAUSE/LAP machine that drives the counter and display path.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 3000,
  parameter int LAP_MAX     = 9
) (
  input  logic       clock_1kHz,
  input  logic       resetn,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  input  logic       mode_active,
  output logic       enable_swt,
  output logic       swt_resetn,
  output logic       lap_capture,
  output logic       display_hold,
  output logic [3:0] lap_count,
  output logic [1:0] state
);

  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = ($clog2(HOLD_MS) > 12) ? $clog2(HOLD_MS) : 12;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // Bit 0 is the start/stop button, bit 1 the lap/reset button.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    acc;
  logic [1:0]    acc_d;
  logic [1:0]    ev;
  logic [DW-1:0] deb_cnt [2];

  assign raw = {btn_lap_reset, btn_start_stop};

  always_ff @(posedge clock_1kHz or negedge resetn) begin
    if (!resetn) begin
      sync1      <= '0;
      sync2      <= '0;
      acc        <= '0;
      acc_d      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      acc_d <= acc;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == acc[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEBOUNCE_MS - 1)) begin
          // This edge is the DEBOUNCE_MS-th consecutive mismatch.
          deb_cnt[i] <= '0;
          acc[i]     <= ~acc[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ev = acc & ~acc_d;

  logic start_ev;
  logic lap_ev;

  // Start/stop takes priority; everything is dropped outside stopwatch mode.
  assign start_ev = ev[0] & mode_active;
  assign lap_ev   = ev[1] & mode_active & ~ev[0];

  state_t        state_q;
  state_t        state_n;
  logic          capture;
  logic          clear;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;

  assign hold_done = (hold_cnt == HW'(HOLD_MS - 1));

  always_comb begin
    state_n = state_q;
    capture = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ev) state_n = RUN;
      end
      RUN: begin
        if (start_ev) begin
          state_n = PAUSE;
        end else if (lap_ev) begin
          state_n = LAP;
          capture = 1'b1;
        end
      end
      LAP: begin
        if (start_ev) begin
          state_n = PAUSE;
        end else if (lap_ev) begin
          capture = 1'b1;
        end else if (hold_done) begin
          state_n = RUN;
        end
      end
      PAUSE: begin
        if (start_ev) begin
          state_n = RUN;
        end else if (lap_ev) begin
          state_n = IDLE;
          clear   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_1kHz or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      enable_swt   <= 1'b0;
      swt_resetn   <= 1'b1;
      lap_capture  <= 1'b0;
      display_hold <= 1'b0;
      lap_count    <= '0;
      hold_cnt     <= '0;
    end else begin
      state_q      <= state_n;
      enable_swt   <= (state_n == RUN) || (state_n == LAP);
      display_hold <= (state_n == LAP);
      lap_capture  <= capture;
      swt_resetn   <= ~clear;
      if (clear) begin
        lap_count <= '0;
      end else if (capture && (lap_count < 4'(LAP_MAX))) begin
        lap_count <= lap_count + 1'b1;
      end
      if (capture) begin
        hold_cnt <= '0;
      end else if (state_q == LAP) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a sample-window debounce model and a rule-level
// state model are compared against the DUT every cycle, plus literal pin points.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int D    = 20;
  localparam int H    = 3000;
  localparam int LMAX = 9;

  // Clock / reset
  logic clock_1kHz = 1'b0;
  logic resetn     = 1'b0;
  always #5 clock_1kHz = ~clock_1kHz;

  logic       btn_s = 1'b0;
  logic       btn_l = 1'b0;
  logic       mode_active = 1'b1;
  logic       enable_swt;
  logic       swt_resetn;
  logic       lap_capture;
  logic       display_hold;
  logic [3:0] lap_count;
  logic [1:0] state;

  stopwatch_ctrl #(.DEBOUNCE_MS(D), .HOLD_MS(H), .LAP_MAX(LMAX)) dut (
    .clock_1kHz    (clock_1kHz),
    .resetn        (resetn),
    .btn_start_stop(btn_s),
    .btn_lap_reset (btn_l),
    .mode_active   (mode_active),
    .enable_swt    (enable_swt),
    .swt_resetn    (swt_resetn),
    .lap_capture   (lap_capture),
    .display_hold  (display_hold),
    .lap_count     (lap_count),
    .state         (state)
  );

  int   checks = 0;
  int   errors = 0;
  logic cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button is accepted once its raw samples, delayed by the
  // two-flop synchronizer, have differed from the accepted level for D samples.
  logic       hist_s[$];
  logic       hist_l[$];
  logic       ma_s, mb_s, ma_l, mb_l;
  logic [1:0] m_state;
  logic       m_en, m_hold, m_cap, m_clr_n;
  int         m_laps;
  int         m_cycle;
  int         m_deadline;

  function automatic logic flips(input logic q[$], input logic acc);
    int sz = q.size();
    for (int i = sz - 1 - D; i <= sz - 2; i++) begin
      if (q[i] == acc) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist_s.delete();
    hist_l.delete();
    for (int i = 0; i < D + 1; i++) begin
      hist_s.push_back(1'b0);
      hist_l.push_back(1'b0);
    end
    ma_s = 1'b0; mb_s = 1'b0; ma_l = 1'b0; mb_l = 1'b0;
    m_state = 2'b00; m_en = 1'b0; m_hold = 1'b0; m_cap = 1'b0; m_clr_n = 1'b1;
    m_laps = 0; m_cycle = 0; m_deadline = 0;
  endtask

  task automatic model_capture();
    m_cap = 1'b1;
    if (m_laps < LMAX) m_laps++;
    m_deadline = m_cycle + H;
  endtask

  task automatic model_step(input logic rs, input logic rl, input logic ma);
    logic ev_s, ev_l, s, l, ns, nl;
    ev_s = ma_s & ~mb_s;
    ev_l = ma_l & ~mb_l;
    s = ev_s & ma;
    l = ev_l & ma & ~s;
    ns = flips(hist_s, ma_s) ? ~ma_s : ma_s;
    nl = flips(hist_l, ma_l) ? ~ma_l : ma_l;
    mb_s = ma_s; ma_s = ns;
    mb_l = ma_l; ma_l = nl;
    hist_s.push_back(rs); void'(hist_s.pop_front());
    hist_l.push_back(rl); void'(hist_l.pop_front());
    m_cycle++;
    m_cap = 1'b0;
    m_clr_n = 1'b1;
    case (m_state)
      2'b00: if (s) m_state = 2'b01;
      2'b01: begin
        if (s) m_state = 2'b10;
        else if (l) begin m_state = 2'b11; model_capture(); end
      end
      2'b11: begin
        if (s) m_state = 2'b10;
        else if (l) model_capture();
        else if (m_cycle == m_deadline) m_state = 2'b01;
      end
      default: begin
        if (s) m_state = 2'b01;
        else if (l) begin m_state = 2'b00; m_clr_n = 1'b0; m_laps = 0; end
      end
    endcase
    m_en   = (m_state == 2'b01) || (m_state == 2'b11);
    m_hold = (m_state == 2'b11);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock_1kHz or negedge resetn);
      if (!resetn) model_reset();
      else model_step(btn_s, btn_l, mode_active);
    end
  end

  // Scoreboard compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clock_1kHz);
      if (cmp_on) begin
        chk("m_state", 32'(state), 32'(m_state));
        chk("m_enable_swt", 32'(enable_swt), 32'(m_en));
        chk("m_display_hold", 32'(display_hold), 32'(m_hold));
        chk("m_lap_capture", 32'(lap_capture), 32'(m_cap));
        chk("m_swt_resetn", 32'(swt_resetn), 32'(m_clr_n));
        chk("m_lap_count", 32'(lap_count), 32'(m_laps));
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clock_1kHz);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_enable_swt"}, 32'(enable_swt), 32'd0);
    chk({tag, "_swt_resetn"}, 32'(swt_resetn), 32'd1);
    chk({tag, "_lap_capture"}, 32'(lap_capture), 32'd0);
    chk({tag, "_display_hold"}, 32'(display_hold), 32'd0);
    chk({tag, "_lap_count"}, 32'(lap_count), 32'd0);
  endtask

  task automatic random_press();
    int which, hold, gap;
    which = $urandom_range(0, 4);
    hold  = $urandom_range(10, 60);
    gap   = $urandom_range(5, 50);
    mode_active = ($urandom_range(0, 7) != 0);
    if ($urandom_range(0, 1) == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (which != 1) btn_s = 1'($urandom_range(0, 1));
        if (which != 0) btn_l = 1'($urandom_range(0, 1));
        tick(1);
      end
    end
    btn_s = (which == 0) || (which >= 3);
    btn_l = (which == 1) || (which >= 3);
    tick(hold);
    btn_s = 1'b0;
    btn_l = 1'b0;
    tick(gap);
  endtask

  initial begin
    tick(3);
    chk_reset_values("reset");
    resetn = 1'b1;
    cmp_on = 1'b1;
    tick(5);

    // Clean start press: RUN exactly 22 edges after the first sampling edge.
    btn_s = 1'b1;
    tick(22);
    chk("start_before", 32'(state), 32'd0);
    tick(1);
    chk("start_run", 32'(state), 32'd1);
    chk("start_enable", 32'(enable_swt), 32'd1);
    tick(27);
    btn_s = 1'b0;
    tick(40);
    chk("release_no_change", 32'(state), 32'd1);

    // Lap in RUN, then auto-exit HOLD_MS cycles after the capture edge.
    btn_l = 1'b1;
    tick(23);
    chk("lap_capture_pulse", 32'(lap_capture), 32'd1);
    chk("lap_hold", 32'(display_hold), 32'd1);
    chk("lap_count_1", 32'(lap_count), 32'd1);
    chk("lap_enable", 32'(enable_swt), 32'd1);
    tick(1);
    chk("lap_capture_one_cycle", 32'(lap_capture), 32'd0);
    btn_l = 1'b0;
    tick(H - 2);
    chk("hold_before_exit", 32'(state), 32'd3);
    tick(1);
    chk("hold_exit_state", 32'(state), 32'd1);
    chk("hold_exit_display", 32'(display_hold), 32'd0);

    // Ten more laps saturate the counter.
    for (int i = 0; i < 10; i++) begin
      btn_l = 1'b1;
      tick(30);
      btn_l = 1'b0;
      tick(30);
    end
    chk("lap_saturate", 32'(lap_count), 32'd9);

    btn_s = 1'b1;
    tick(23);
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_enable", 32'(enable_swt), 32'd0);
    btn_s = 1'b0;
    tick(30);

    btn_l = 1'b1;
    tick(23);
    chk("clear_pulse", 32'(swt_resetn), 32'd0);
    chk("clear_lap_count", 32'(lap_count), 32'd0);
    chk("clear_idle", 32'(state), 32'd0);
    tick(1);
    chk("clear_one_cycle", 32'(swt_resetn), 32'd1);
    btn_l = 1'b0;
    tick(30);

    // Bouncy start: bursts shorter than the debounce window, then stable.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 5; i++) begin
        btn_s = 1'($urandom_range(0, 1));
        tick(1);
      end
      btn_s = 1'b0;
      tick($urandom_range(1, 8));
    end
    btn_s = 1'b1;
    tick(22);
    chk("bounce_before", 32'(state), 32'd0);
    tick(1);
    chk("bounce_run", 32'(state), 32'd1);
    tick(20);
    btn_s = 1'b0;
    tick(30);

    // Both buttons accepted together in RUN: start wins.
    btn_s = 1'b1;
    btn_l = 1'b1;
    tick(23);
    chk("both_pause", 32'(state), 32'd2);
    chk("both_no_capture", 32'(lap_capture), 32'd0);
    chk("both_lap_count", 32'(lap_count), 32'd0);
    btn_s = 1'b0;
    btn_l = 1'b0;
    tick(30);

    // Mode inactive: presses are discarded.
    mode_active = 1'b0;
    btn_s = 1'b1;
    tick(30);
    chk("mode_off_start", 32'(state), 32'd2);
    btn_s = 1'b0;
    btn_l = 1'b1;
    tick(30);
    chk("mode_off_lap", 32'(state), 32'd2);
    btn_l = 1'b0;
    tick(30);
    mode_active = 1'b1;

    // Randomized presses, bounce and mode changes.
    for (int i = 0; i < 40; i++) random_press();

    // Reach LAP from a clean reset, then reset mid-hold with start held.
    mode_active = 1'b1;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(3);
    btn_s = 1'b1;
    tick(30);
    btn_s = 1'b0;
    tick(30);
    btn_l = 1'b1;
    tick(30);
    btn_l = 1'b0;
    tick(100);
    chk("pre_reset_lap", 32'(state), 32'd3);
    btn_s = 1'b1;
    tick(5);
    #2 resetn = 1'b0;
    #1 chk_reset_values("async_reset");
    tick(3);
    resetn = 1'b1;
    tick(22);
    chk("held_before", 32'(state), 32'd0);
    tick(1);
    chk("held_run", 32'(state), 32'd1);
    chk("held_enable", 32'(enable_swt), 32'd1);
    btn_s = 1'b0;
    tick(30);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
